// File: rtl/sample_streamer.sv
// Streams a window of multi-byte samples from capture memory to the UART.
// Window may wrap the circular buffer; optional idle gap between samples.
module sample_streamer #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned SAMPLE_BYTES = 1,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned GAP_CYCLES   = 0
) (
  input  logic                      clk_50mhz,
  input  logic                      reset,
  input  logic                      activate,
  input  logic [ADDR_W-1:0]         start_addr,
  input  logic [ADDR_W:0]           count,
  output logic                      done,
  output logic                      busy,
  output logic [ADDR_W:0]           sent,
  input  logic                      tx_active,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_oe,
  input  logic [8*SAMPLE_BYTES-1:0] mem_data
);

  localparam int unsigned DW = 8 * SAMPLE_BYTES;
  localparam logic [2:0]  LAT_LAST = 3'(MEM_LATENCY - 1);
  localparam logic [23:0] GAP_LAST = 24'(GAP_CYCLES - 1);
  localparam logic [1:0]  IDX_LAST = 2'(SAMPLE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SEND, S_DRAIN, S_GAP, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] count_q, sent_q, sent_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0]   sh_q, sh_nxt;
  logic [1:0]      idx_q;
  logic [2:0]      lat_q;
  logic [23:0]     gap_q;
  logic            last_byte;
  logic            done_q, busy_q, txs_q, oe_q;
  logic [7:0]      txd_q;

  assign sent_inc  = sent_q + (ADDR_W+1)'(1);
  assign sh_nxt    = sh_q << 8;
  assign last_byte = (idx_q == IDX_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (activate)
          state_d = (count == '0) ? S_DONE : S_FETCH;
      S_FETCH:
        if (!activate)               state_d = S_DONE;
        else if (lat_q == LAT_LAST)  state_d = S_LOAD;
      S_LOAD:
        state_d = activate ? S_SEND : S_DONE;
      S_SEND:
        if (tx_active) state_d = S_DRAIN;
      S_DRAIN:
        if (!tx_active) begin
          if (!last_byte)
            state_d = activate ? S_SEND : S_DONE;
          else if (!activate || sent_inc == count_q)
            state_d = S_DONE;
          else
            state_d = (GAP_CYCLES > 0) ? S_GAP : S_FETCH;
        end
      S_GAP:
        if (!activate)               state_d = S_DONE;
        else if (gap_q == GAP_LAST)  state_d = S_FETCH;
      S_DONE:
        if (!activate && !tx_active) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      sent_q  <= '0;
      addr_q  <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      txs_q   <= 1'b0;
      oe_q    <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == S_DONE);
      busy_q  <= !(state_d inside {S_IDLE, S_DONE});
      txs_q   <= (state_d == S_SEND);
      oe_q    <= (state_d == S_FETCH) || (state_d == S_LOAD);
      lat_q   <= (state_q == S_FETCH && state_d == S_FETCH) ?
                 lat_q + 3'd1 : '0;
      gap_q   <= (state_q == S_GAP && state_d == S_GAP) ?
                 gap_q + 24'd1 : '0;
      if (state_q == S_IDLE && activate) begin
        count_q <= count;
        sent_q  <= '0;
        addr_q  <= start_addr;
      end
      if (state_q == S_LOAD) begin
        sh_q  <= mem_data;
        idx_q <= '0;
      end
      // only whole samples advance sent and the read address
      if (state_q == S_DRAIN && !tx_active) begin
        if (last_byte) begin
          sent_q <= sent_inc;
          addr_q <= addr_q + ADDR_W'(1);
        end else begin
          idx_q <= idx_q + 2'd1;
          sh_q  <= sh_nxt;
        end
      end
      if (state_d == S_IDLE) addr_q <= '0;
      if (state_d != S_SEND)       txd_q <= '0;
      else if (state_q == S_LOAD)  txd_q <= mem_data[DW-1 -: 8];
      else if (state_q == S_DRAIN) txd_q <= sh_nxt[DW-1 -: 8];
    end
  end

  assign done     = done_q;
  assign busy     = busy_q;
  assign sent     = sent_q;
  assign tx_start = txs_q;
  assign tx_data  = txd_q;
  assign mem_addr = addr_q;
  assign mem_oe   = oe_q;

endmodule

// File: tb/tb_sample_streamer.sv
// Bench for sample_streamer: two instances (1-byte default, 2-byte/lat2/gap5)
// driven with directed and random windows, checked against a window model.
module tb_sample_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        act [2];
  logic [7:0]  saddr [2];
  logic [8:0]  cnt [2];
  logic        done_o [2];
  logic        busy_o [2];
  logic [8:0]  sent_o [2];
  logic        txs [2];
  logic [7:0]  txd [2];
  logic [7:0]  maddr [2];
  logic        moe [2];
  logic        txa [2];

  logic [7:0]  mem_a [256];
  logic [15:0] mem_b [256];
  logic [7:0]  rd_a;
  logic [15:0] rd_b1, rd_b2;

  int bcnt [2];
  int ncap [2];
  int moe_cnt [2];
  int nxt_len [2] = '{10, 10};
  logic [7:0] cap_byte [2][1024];
  int cap_cyc [2][1024];
  int cap_len [2][1024];
  int cyc = 0;
  int ulo = 10;
  int uhi = 10;
  int nchk = 0;
  int nerr = 0;

  sample_streamer #(
    .ADDR_W(8), .SAMPLE_BYTES(1), .MEM_LATENCY(1), .GAP_CYCLES(0)
  ) u_a (
    .clk_50mhz(clk), .reset(rst[0]), .activate(act[0]),
    .start_addr(saddr[0]), .count(cnt[0]), .done(done_o[0]),
    .busy(busy_o[0]), .sent(sent_o[0]), .tx_active(txa[0]),
    .tx_start(txs[0]), .tx_data(txd[0]), .mem_addr(maddr[0]),
    .mem_oe(moe[0]), .mem_data(rd_a)
  );

  sample_streamer #(
    .ADDR_W(8), .SAMPLE_BYTES(2), .MEM_LATENCY(2), .GAP_CYCLES(5)
  ) u_b (
    .clk_50mhz(clk), .reset(rst[1]), .activate(act[1]),
    .start_addr(saddr[1]), .count(cnt[1]), .done(done_o[1]),
    .busy(busy_o[1]), .sent(sent_o[1]), .tx_active(txa[1]),
    .tx_start(txs[1]), .tx_data(txd[1]), .mem_addr(maddr[1]),
    .mem_oe(moe[1]), .mem_data(rd_b2)
  );

  assign txa[0] = (bcnt[0] != 0);
  assign txa[1] = (bcnt[1] != 0);

  // memories with 1- and 2-cycle read latency, plus a UART per instance
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd_a  <= mem_a[maddr[0]];
    rd_b1 <= mem_b[maddr[1]];
    rd_b2 <= rd_b1;
    for (int d = 0; d < 2; d++) begin
      if (moe[d]) moe_cnt[d] <= moe_cnt[d] + 1;
      if (bcnt[d] != 0) begin
        bcnt[d] <= bcnt[d] - 1;
      end else if (txs[d]) begin
        bcnt[d] <= nxt_len[d];
        cap_byte[d][ncap[d] % 1024] <= txd[d];
        cap_cyc[d][ncap[d] % 1024]  <= cyc;
        cap_len[d][ncap[d] % 1024]  <= nxt_len[d];
        ncap[d]    <= ncap[d] + 1;
        nxt_len[d] <= int'($urandom_range(uhi, ulo));
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // byte j of the window: sample j/sb, MSB first within the sample
  function automatic logic [7:0] exp_byte(int d, int start, int j);
    int sb = d + 1;
    int a = (start + j / sb) % 256;
    logic [15:0] w = (d == 1) ? mem_b[a] : {8'h00, mem_a[a]};
    return 8'(w >> (8 * (sb - 1 - (j % sb))));
  endfunction

  task automatic run(int d, int start, int n, int abort_m);
    int sb = d + 1;
    int ml = d + 1;
    int gap = (d == 1) ? 5 : 0;
    int nexp, nsent, base, moe0, e, t, j0, j1;
    t = 0;
    while (txa[d] && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    base = ncap[d];
    moe0 = moe_cnt[d];
    saddr[d] = 8'(start);
    cnt[d] = 9'(n);
    act[d] = 1'b1;
    e = cyc;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (abort_m > 0 && act[d] && ncap[d] - base >= abort_m)
        act[d] = 1'b0;
    end while (!done_o[d] && t < 20000);
    chk("done_seen", done_o[d], 1);
    nexp  = (abort_m > 0) ? abort_m : n * sb;
    nsent = (abort_m > 0) ? abort_m / sb : n;
    chk("sent", sent_o[d], nsent);
    chk("nbytes", ncap[d] - base, nexp);
    chk("addr_end", maddr[d], (start + nsent) % 256);
    chk("busy_done", busy_o[d], 0);
    chk("txs_done", txs[d], 0);
    chk("oe_done", moe[d], 0);
    for (int j = 0; j < nexp && j < ncap[d] - base; j++) begin
      j1 = (base + j) % 1024;
      j0 = (base + j + 1023) % 1024;
      chk("byte", cap_byte[d][j1], exp_byte(d, start, j));
      if (j == 0)
        chk("lat_first", cap_cyc[d][j1] - e, 2 + ml);
      else
        chk("lat_byte", cap_cyc[d][j1] - cap_cyc[d][j0],
            cap_len[d][j0] + 2 + ((j % sb == 0) ? gap + ml + 1 : 0));
    end
    if (n == 0) begin
      chk("zero_lat", t, 1);
      chk("zero_oe", moe_cnt[d] - moe0, 0);
    end
    act[d] = 1'b0;
    @(negedge clk);
    chk("release", done_o[d], 0);
  endtask

  task automatic reset_mid();
    int base, t;
    ulo = 6;
    uhi = 6;
    t = 0;
    while (txa[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    base = ncap[0];
    saddr[0] = 8'd100;
    cnt[0] = 9'd20;
    act[0] = 1'b1;
    t = 0;
    while (ncap[0] - base < 2 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach", (ncap[0] - base >= 2), 1);
    @(negedge clk);
    chk("rst_in_drain", busy_o[0] && !txs[0], 1);
    rst[0] = 1'b1;
    act[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_done", done_o[0], 0);
    chk("rst_busy", busy_o[0], 0);
    chk("rst_sent", sent_o[0], 0);
    chk("rst_txs", txs[0], 0);
    chk("rst_txd", txd[0], 0);
    chk("rst_addr", maddr[0], 0);
    chk("rst_oe", moe[0], 0);
    @(negedge clk);
    rst[0] = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      act[d] = 1'b0;
      saddr[d] = '0;
      cnt[d] = '0;
    end
    for (int a = 0; a < 256; a++) begin
      mem_a[a] = 8'(a);
      mem_b[a] = 16'($urandom);
    end
    mem_b[0] = 16'h1234;
    // activate alongside reset: reset must win
    act[0] = 1'b1;
    cnt[0] = 9'd5;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("init_done", done_o[d], 0);
      chk("init_busy", busy_o[d], 0);
      chk("init_sent", sent_o[d], 0);
      chk("init_txs", txs[d], 0);
      chk("init_oe", moe[d], 0);
      chk("init_addr", maddr[d], 0);
    end
    act[0] = 1'b0;
    cnt[0] = '0;
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy_o[0], 0);

    run(0, 10, 3, 0);
    run(0, 254, 4, 0);
    ulo = 1;
    uhi = 3;
    run(0, int'($urandom_range(255)), 256, 0);
    ulo = 10;
    uhi = 10;
    run(1, 0, 3, 0);
    run(0, 77, 0, 0);
    run(1, 5, 0, 0);
    run(1, 0, 5, 3);
    run(0, 30, 5, 2);
    reset_mid();
    run(0, 200, 3, 0);

    ulo = 1;
    uhi = 5;
    for (int i = 0; i < 12; i++) begin
      int d, n, m;
      d = i % 2;
      for (int a = 0; a < 256; a++) begin
        mem_a[a] = 8'($urandom);
        mem_b[a] = 16'($urandom);
      end
      n = int'($urandom_range(12, 1));
      m = 0;
      if ($urandom_range(1, 0) == 1)
        m = int'($urandom_range(n * (d + 1), 1));
      run(d, int'($urandom_range(255)), n, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
